// File: rtl/uart_tx_framer.sv
// UART transmit framer: buffers bytes and sends start, 8 data bits LSB-first, parity, stop.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise a single holding register.
module uart_tx_framer #(
   parameter int   FIFO_DEPTH = 4,
   parameter logic PARITY_ODD = 1'b0
) (
   input  logic       clk_baud,
   input  logic       rst,
   input  logic       tx_rx_start,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done,
   output logic [2:0] current_state_tx,
   output logic [2:0] fifo_count
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_START    = 3'd1;
   localparam logic [2:0] ST_TRANSMIT = 3'd2;
   localparam logic [2:0] ST_PARITY   = 3'd3;
   localparam logic [2:0] ST_STOP     = 3'd4;

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_framer: FIFO_DEPTH must be a power of two >= 2");
   end

   logic [2:0] state_q, state_d;
   logic       tx_q, tx_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       parity_q, parity_d;
   logic       push_s, pop_s, have_data_s;
   logic [7:0] head_s;

   assign push_s = data_valid & data_ready;
   assign pop_s  = tx_rx_start & have_data_s & ((state_q == ST_IDLE) | (state_q == ST_STOP));

`ifdef UART_TX_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   assign have_data_s = (count_q != '0);
   assign head_s      = mem_q[rd_ptr_q];
   assign data_ready  = (count_q < CW'(FIFO_DEPTH));
   assign fifo_count  = 3'(count_q);

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_baud) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   always_ff @(posedge clk_baud) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (push_s && !pop_s) begin
            count_q <= count_q + CW'(1);
         end else if (pop_s && !push_s) begin
            count_q <= count_q - CW'(1);
         end
      end
   end
`else
   logic [7:0] hold_q;
   logic       full_q;

   assign have_data_s = full_q;
   assign head_s      = hold_q;
   assign data_ready  = ~full_q;
   assign fifo_count  = {2'b00, full_q};

   // Ready is low while full, so push and pop never coincide.
   always_ff @(posedge clk_baud) begin
      if (rst) begin
         hold_q <= 8'h00;
         full_q <= 1'b0;
      end else if (push_s) begin
         hold_q <= data_in;
         full_q <= 1'b1;
      end else if (pop_s) begin
         full_q <= 1'b0;
      end
   end
`endif

   // tx_d is the bit belonging to state_d, so the line changes together with the state.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      tx_d      = 1'b1;
      case (state_q)
         ST_IDLE, ST_STOP: begin
            if (pop_s) begin
               state_d  = ST_START;
               shift_d  = head_s;
               parity_d = (^head_s) ^ PARITY_ODD;
               tx_d     = 1'b0;
            end else begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end
         end
         ST_START: begin
            state_d   = ST_TRANSMIT;
            bit_cnt_d = 3'd0;
            tx_d      = shift_q[0];
         end
         ST_TRANSMIT: begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               state_d = ST_PARITY;
               tx_d    = parity_q;
            end else begin
               state_d = ST_TRANSMIT;
               tx_d    = shift_d[0];
            end
         end
         ST_PARITY: begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_baud) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tx_q      <= 1'b1;
         shift_q   <= 8'h00;
         bit_cnt_q <= 3'd0;
         parity_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
      end
   end

   assign tx               = tx_q;
   assign tx_busy          = (state_q != ST_IDLE);
   assign tx_done          = (state_q == ST_STOP);
   assign current_state_tx = state_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: an even-parity and an odd-parity instance share one stimulus
// and are compared every cycle against a frame-position reference model.
module tb_uart_tx_framer;

`ifdef UART_TX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk_baud = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] din = 8'h00;
   logic       ready0, tx0, busy0, done0, ready1, tx1, busy1, done1;
   logic [2:0] st0, cnt0, st1, cnt1;

   always #5 clk_baud = ~clk_baud;

   uart_tx_framer #(.FIFO_DEPTH(4), .PARITY_ODD(1'b0)) u_even (
      .clk_baud(clk_baud), .rst(rst), .tx_rx_start(en), .data_in(din), .data_valid(valid),
      .data_ready(ready0), .tx(tx0), .tx_busy(busy0), .tx_done(done0),
      .current_state_tx(st0), .fifo_count(cnt0));

   uart_tx_framer #(.FIFO_DEPTH(4), .PARITY_ODD(1'b1)) u_odd (
      .clk_baud(clk_baud), .rst(rst), .tx_rx_start(en), .data_in(din), .data_valid(valid),
      .data_ready(ready1), .tx(tx1), .tx_busy(busy1), .tx_done(done1),
      .current_state_tx(st1), .fifo_count(cnt1));

   wire [19:0] obs = {tx0, tx1, busy0, done0, st0, cnt0, ready0, busy1, done1, st1, cnt1, ready1};

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mq[$];
   logic [7:0] pend[$];
   int         pos = -1;
   logic [7:0] cur = 8'h00;
   logic [19:0] exp_vec;

   // Reference: pos is the cycle index within the current frame (-1 = idle, 0 = start .. 10 = stop).
   task automatic model_step();
      int   sz;
      logic push, start, etx0, etx1, eb, ed, erdy;
      logic [2:0] est, ecnt;
      sz = mq.size();
      if (rst) begin
         mq.delete();
         pos = -1;
      end else begin
         push  = valid && (sz < DEPTH);
         start = en && (sz > 0) && ((pos == -1) || (pos == 10));
         if (start) begin
            cur = mq.pop_front();
            pos = 0;
         end else if (pos == 10) begin
            pos = -1;
         end else if (pos >= 0) begin
            pos++;
         end
         if (push) begin
            mq.push_back(din);
            void'(pend.pop_front());
         end
      end
      if (pos == -1)     begin etx0 = 1'b1; est = 3'd0; end
      else if (pos == 0) begin etx0 = 1'b0; est = 3'd1; end
      else if (pos <= 8) begin etx0 = cur[pos-1]; est = 3'd2; end
      else if (pos == 9) begin etx0 = ^cur; est = 3'd3; end
      else               begin etx0 = 1'b1; est = 3'd4; end
      etx1 = (pos == 9) ? ~(^cur) : etx0;
      eb   = (pos >= 0);
      ed   = (pos == 10);
      ecnt = 3'(mq.size());
      erdy = (mq.size() < DEPTH);
      exp_vec = {etx0, etx1, eb, ed, est, ecnt, erdy, eb, ed, est, ecnt, erdy};
   endtask

   // Drive inputs from the pending list, advance the model, then one clock (sample on negedge).
   task automatic tick();
      if (pend.size() > 0) begin
         valid = 1'b1;
         din   = pend[0];
      end else begin
         valid = 1'b0;
         din   = 8'($urandom);
      end
      model_step();
      @(posedge clk_baud);
      @(negedge clk_baud);
   endtask

   task automatic test_reset();
      logic [19:0] rvec;
      rvec = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1};
      rst = 1'b1; en = 1'b0; pend.delete();
      tick(); tick();
      checks++;
      if (obs !== rvec) begin errors++; $display("FAIL reset_values: got %b expected %b", obs, rvec); end
      checks++;
      if (obs !== exp_vec) begin errors++; $display("FAIL reset_model: got %b expected %b", obs, exp_vec); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_a5();
      logic [0:11] seq;
      int nbusy, ndone;
      seq = 12'b010100101011;
      nbusy = 0; ndone = 0;
      en = 1'b1;
      pend.push_back(8'hA5);
      tick();
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL a5_model cyc %0d: got %b expected %b", i, obs, exp_vec); end
         checks++;
         if (tx0 !== seq[i]) begin errors++; $display("FAIL a5_tx cyc %0d: got %b expected %b", i, tx0, seq[i]); end
         if (busy0 === 1'b1) nbusy++;
         if (done0 === 1'b1) ndone++;
      end
      checks++;
      if (nbusy != 11) begin errors++; $display("FAIL a5_busy_len: got %0d expected 11", nbusy); end
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL a5_done_count: got %0d expected 1", ndone); end
   endtask

   task automatic test_back_to_back();
      logic [0:21] seq;
      int first, last, nbusy, d1, d2;
      seq = 22'b01000000011_00000000111;
      first = -1; last = -1; nbusy = 0; d1 = -1; d2 = -1;
      en = 1'b1;
      pend.push_back(8'h01);
      pend.push_back(8'h80);
      for (int i = 0; i < 26; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL b2b_model cyc %0d: got %b expected %b", i, obs, exp_vec); end
         if (busy0 === 1'b1) begin
            if (first < 0) first = i;
            last = i;
            nbusy++;
         end
         if (done0 === 1'b1) begin
            if (d1 < 0) d1 = i; else d2 = i;
         end
         if (i >= 1 && i <= 22) begin
            checks++;
            if (tx0 !== seq[i-1]) begin errors++; $display("FAIL b2b_tx cyc %0d: got %b expected %b", i, tx0, seq[i-1]); end
         end
      end
      checks++;
      if (first != 1) begin errors++; $display("FAIL b2b_latency: got %0d expected 1", first); end
      checks++;
      if (nbusy != 22 || (last - first + 1) != 22) begin
         errors++; $display("FAIL b2b_contiguous: got %0d busy over span %0d expected 22", nbusy, last - first + 1);
      end
      checks++;
      if (d2 - d1 != 11) begin errors++; $display("FAIL b2b_done_spacing: got %0d expected 11", d2 - d1); end
   endtask

   task automatic test_fill();
      int ndone;
      ndone = 0;
      en = 1'b0;
      for (int b = 0; b < 5; b++) pend.push_back(8'h10 + 8'(b));
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL fill_model cyc %0d: got %b expected %b", i, obs, exp_vec); end
      end
      checks++;
      if (cnt0 !== 3'(DEPTH) || ready0 !== 1'b0 || tx0 !== 1'b1) begin
         errors++; $display("FAIL fill_full: got count %0d ready %b tx %b expected count %0d ready 0 tx 1", cnt0, ready0, tx0, DEPTH);
      end
      en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL fill_drain cyc %0d: got %b expected %b", i, obs, exp_vec); end
         if (done0 === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 5) begin errors++; $display("FAIL fill_frames: got %0d expected 5", ndone); end
   endtask

   task automatic test_parity();
      logic [7:0] bytes [3];
      logic       pe [3];
      logic       po [3];
      bytes = '{8'h00, 8'hFF, 8'h07};
      pe    = '{1'b0, 1'b0, 1'b1};
      po    = '{1'b1, 1'b1, 1'b0};
      en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pend.push_back(bytes[k]);
         for (int i = 0; i < 13; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec) begin errors++; $display("FAIL parity_model byte %h cyc %0d: got %b expected %b", bytes[k], i, obs, exp_vec); end
            if (pos == 9) begin
               checks++;
               if (tx0 !== pe[k] || tx1 !== po[k]) begin
                  errors++; $display("FAIL parity_bit byte %h: got even %b odd %b expected even %b odd %b", bytes[k], tx0, tx1, pe[k], po[k]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [0:10] seq;
      int n, ndone;
      seq = 11'b00011110001;
      n = 0; ndone = 0;
      en = 1'b1;
      for (int b = 0; b < 3; b++) pend.push_back(8'($urandom));
      while (pos != 4 && n < 40) begin
         tick();
         n++;
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL rstmid_model cyc %0d: got %b expected %b", n, obs, exp_vec); end
      end
      checks++;
      if (pos != 4) begin errors++; $display("FAIL rstmid_timeout: got pos %0d expected 4", pos); end
      pend.delete();
      rst = 1'b1;
      tick();
      checks++;
      if (tx0 !== 1'b1 || st0 !== 3'd0 || cnt0 !== 3'd0 || done0 !== 1'b0) begin
         errors++; $display("FAIL rstmid_abort: got tx %b state %0d count %0d done %b expected 1 0 0 0", tx0, st0, cnt0, done0);
      end
      rst = 1'b0;
      pend.push_back(8'h3C);
      for (int i = 0; i < 14; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL rstmid_3c_model cyc %0d: got %b expected %b", i, obs, exp_vec); end
         if (i >= 1 && i <= 11) begin
            checks++;
            if (tx0 !== seq[i-1]) begin errors++; $display("FAIL rstmid_3c_tx cyc %0d: got %b expected %b", i, tx0, seq[i-1]); end
         end
         if (done0 === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL rstmid_done_count: got %0d expected 1", ndone); end
   endtask

   task automatic test_enable_drop();
      int n;
      n = 0;
      en = 1'b1;
      pend.push_back(8'($urandom));
      pend.push_back(8'($urandom));
      while (pos != 9 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (pos != 9 || st0 !== 3'd3) begin errors++; $display("FAIL endrop_reach_parity: got state %0d expected 3", st0); end
      en = 1'b0;
      tick();
      checks++;
      if (st0 !== 3'd4 || done0 !== 1'b1) begin errors++; $display("FAIL endrop_stop: got state %0d done %b expected 4 1", st0, done0); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (st0 !== 3'd0 || cnt0 !== 3'd1 || tx0 !== 1'b1) begin
            errors++; $display("FAIL endrop_idle cyc %0d: got state %0d count %0d tx %b expected 0 1 1", i, st0, cnt0, tx0);
         end
      end
      en = 1'b1;
      tick();
      checks++;
      if (st0 !== 3'd1 || cnt0 !== 3'd0 || tx0 !== 1'b0) begin
         errors++; $display("FAIL endrop_restart: got state %0d count %0d tx %b expected 1 0 0", st0, cnt0, tx0);
      end
      for (int i = 0; i < 11; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL endrop_model cyc %0d: got %b expected %b", i, obs, exp_vec); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en  = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 149) == 0);
         if (pend.size() == 0 && $urandom_range(0, 2) == 0) pend.push_back(8'($urandom));
         tick();
         checks++;
         if (obs !== exp_vec) begin errors++; $display("FAIL random_model cyc %0d: got %b expected %b", i, obs, exp_vec); end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_a5();
      test_back_to_back();
      test_fill();
      test_parity();
      test_reset_mid();
      test_enable_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
